// File: rtl/ahb_arb_pkg.sv
// rtl/ahb_arb_pkg.sv - AHB arbiter encodings, FSM states and burst constants
package ahb_arb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;

   localparam int INCR4_BEATS = 4;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_OWN   = 2'd1,
      ARB_BURST = 2'd2
   } arb_state_e;

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// rtl/ahb_bus_arbiter_if.sv - arbiter bus bundle; HLOCK/HMASTLOCK exist only with AHB_ARB_LOCK_EN
interface ahb_bus_arbiter_if #(
   parameter int NUM_MASTERS = 4
);
   logic [NUM_MASTERS-1:0]         HBUSREQ;
   logic [1:0]                     HTRANS;
   logic [2:0]                     HBURST;
   logic                           HREADY;
   logic [NUM_MASTERS-1:0]         HGRANT;
   logic [$clog2(NUM_MASTERS)-1:0] HMASTER;
`ifdef AHB_ARB_LOCK_EN
   logic [NUM_MASTERS-1:0]         HLOCK;
   logic                           HMASTLOCK;

   modport master (output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
                   input  HGRANT, HMASTER, HMASTLOCK);
   modport slave  (input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
                   output HGRANT, HMASTER, HMASTLOCK);
`else
   modport master (output HBUSREQ, HTRANS, HBURST, HREADY,
                   input  HGRANT, HMASTER);
   modport slave  (input  HBUSREQ, HTRANS, HBURST, HREADY,
                   output HGRANT, HMASTER);
`endif
endinterface

// File: rtl/ahb_rr_picker.sv
// rtl/ahb_rr_picker.sv - combinational round-robin search starting after last_idx
module ahb_rr_picker #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] last_idx,
   output logic [$clog2(N)-1:0] win_idx,
   output logic                 win_valid
);
   localparam int W = $clog2(N);

   int cand;

   // walk last+1 .. last+N (wrapping) so last_idx itself is checked last
   always_comb begin
      win_idx   = '0;
      win_valid = 1'b0;
      cand      = 0;
      for (int i = 1; i <= N; i++) begin
         cand = (int'(last_idx) + i) % N;
         if (!win_valid && req[cand[W-1:0]]) begin
            win_valid = 1'b1;
            win_idx   = cand[W-1:0];
         end
      end
   end
endmodule

// File: rtl/ahb_bus_arbiter.sv
// rtl/ahb_bus_arbiter.sv - round-robin AHB-Lite arbiter with INCR4 protection; optional AHB_ARB_LOCK_EN
module ahb_bus_arbiter
   import ahb_arb_pkg::*;
#(
   parameter int NUM_MASTERS    = 4,
   parameter int DEFAULT_MASTER = 0
) (
   input logic              HCLK,
   input logic              HRESET,
   ahb_bus_arbiter_if.slave bus
);
   localparam int            W       = $clog2(NUM_MASTERS);
   localparam logic [W-1:0]  DEF_IDX = W'(DEFAULT_MASTER);
   localparam logic [1:0]    LAST_BEAT = 2'(INCR4_BEATS - 1);

   arb_state_e             state_q, state_d;
   logic [1:0]             beat_cnt_q, beat_cnt_d;
   logic [W-1:0]           grant_q, grant_d;
   logic [W-1:0]           hmaster_q, hmaster_d;
   logic [W-1:0]           pick_idx;
   logic                   pick_valid;
   logic                   rearb;
   logic                   lock_hold;
   logic [NUM_MASTERS-1:0] hgrant;

   ahb_rr_picker #(.N(NUM_MASTERS)) u_picker (
      .req       (bus.HBUSREQ),
      .last_idx  (grant_q),
      .win_idx   (pick_idx),
      .win_valid (pick_valid)
   );

`ifdef AHB_ARB_LOCK_EN
   logic hmastlock_q, hmastlock_d;
   // the registered lock bit keeps the grant for one more accepted beat after HLOCK drops
   assign lock_hold = bus.HLOCK[grant_q] | hmastlock_q;
`else
   assign lock_hold = 1'b0;
`endif

   // state register: FSM, beat counter, grant and address-phase owner
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q    <= ARB_IDLE;
         beat_cnt_q <= '0;
         grant_q    <= DEF_IDX;
         hmaster_q  <= DEF_IDX;
`ifdef AHB_ARB_LOCK_EN
         hmastlock_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         grant_q    <= grant_d;
         hmaster_q  <= hmaster_d;
`ifdef AHB_ARB_LOCK_EN
         hmastlock_q <= hmastlock_d;
`endif
      end
   end

   // next state: everything advances only on accepted (HREADY=1) cycles
   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      grant_d    = grant_q;
      hmaster_d  = hmaster_q;
      rearb      = 1'b0;
`ifdef AHB_ARB_LOCK_EN
      hmastlock_d = hmastlock_q;
`endif
      if (bus.HREADY) begin
         hmaster_d = grant_q;
`ifdef AHB_ARB_LOCK_EN
         hmastlock_d = bus.HLOCK[grant_q];
`endif
         case (state_q)
            ARB_IDLE: rearb = pick_valid;
            ARB_OWN: begin
               if (bus.HTRANS == HTRANS_NONSEQ && bus.HBURST == HBURST_INCR4) begin
                  state_d    = ARB_BURST;
                  beat_cnt_d = 2'd1;
               end else begin
                  rearb = !lock_hold;
               end
            end
            ARB_BURST: begin
               if (bus.HTRANS == HTRANS_SEQ) begin
                  if (beat_cnt_q == LAST_BEAT) begin
                     rearb      = 1'b1;
                     beat_cnt_d = '0;
                  end else begin
                     beat_cnt_d = beat_cnt_q + 2'd1;
                  end
               end else if (bus.HTRANS != HTRANS_BUSY) begin
                  rearb      = 1'b1;
                  beat_cnt_d = '0;
               end
            end
            default: begin
               state_d    = ARB_IDLE;
               beat_cnt_d = '0;
            end
         endcase
         if (rearb) begin
            if (pick_valid) begin
               grant_d = pick_idx;
               state_d = ARB_OWN;
            end else begin
               grant_d = DEF_IDX;
               state_d = ARB_IDLE;
            end
         end
      end
   end

   // outputs: one-hot grant decoded straight from the grant register
   always_comb begin
      hgrant          = '0;
      hgrant[grant_q] = 1'b1;
      bus.HGRANT      = hgrant;
      bus.HMASTER     = hmaster_q;
`ifdef AHB_ARB_LOCK_EN
      bus.HMASTLOCK   = hmastlock_q;
`endif
   end
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb/tb_ahb_bus_arbiter.sv - scoreboard bench for ahb_bus_arbiter
module tb_ahb_bus_arbiter;
   import ahb_arb_pkg::*;

   typedef struct {
      logic [3:0] req;
      logic [1:0] trans;
      logic [2:0] burst;
      logic       rdy;
      logic       rst;
      logic [3:0] lock;
      logic [3:0] grant;
      logic [1:0] master;
      logic [1:0] cnt;
      arb_state_e st;
      logic       mlock;
   } step_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   int    n_tests = 0;
   int    n_fail  = 0;
   step_t exp_q[$];

   ahb_bus_arbiter_if #(.NUM_MASTERS(4)) bus_if ();

   ahb_bus_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
      .HCLK   (clk),
      .HRESET (rst),
      .bus    (bus_if)
   );

   always #5 clk = ~clk;

   task automatic apply(input step_t s);
      rst            = s.rst;
      bus_if.HBUSREQ = s.req;
      bus_if.HTRANS  = s.trans;
      bus_if.HBURST  = s.burst;
      bus_if.HREADY  = s.rdy;
`ifdef AHB_ARB_LOCK_EN
      bus_if.HLOCK   = s.lock;
`endif
   endtask

   task automatic do_reset();
      step_t s = '{4'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b1, 4'b0, 4'b0001, 2'd0, 2'd0, ARB_IDLE, 1'b0};
      apply(s);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      step_t e;
      step_t tbl[5] = '{
         '{4'b0110, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b1, 4'b0, 4'b0001, 2'd0, 2'd0, ARB_IDLE, 1'b0},
         '{4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 1'b0, 4'b0, 4'b0001, 2'd0, 2'd0, ARB_IDLE, 1'b0},
         '{4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 1'b0, 4'b0, 4'b0001, 2'd0, 2'd0, ARB_IDLE, 1'b0},
         '{4'b0100, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b0, 4'b0, 4'b0001, 2'd0, 2'd0, ARB_IDLE, 1'b0},
         '{4'b0100, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 1'b0, 4'b0, 4'b0100, 2'd0, 2'd0, ARB_OWN,  1'b0}
      };
      foreach (tbl[i]) begin
         apply(tbl[i]); exp_q.push_back(tbl[i]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         n_tests++; if (bus_if.HGRANT !== e.grant) begin n_fail++; $display("FAIL reset_grant[%0d]: got %b need %b", i, bus_if.HGRANT, e.grant); end
         n_tests++; if (bus_if.HMASTER !== e.master) begin n_fail++; $display("FAIL reset_master[%0d]: got %0d need %0d", i, bus_if.HMASTER, e.master); end
         n_tests++; if (dut.beat_cnt_q !== e.cnt) begin n_fail++; $display("FAIL reset_cnt[%0d]: got %0d need %0d", i, dut.beat_cnt_q, e.cnt); end
         n_tests++; if (dut.state_q !== e.st) begin n_fail++; $display("FAIL reset_state[%0d]: got %0d need %0d", i, dut.state_q, e.st); end
      end
   endtask

   task automatic test_round_robin();
      step_t e;
      step_t tbl[7] = '{
         '{4'b0110, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0, 4'b0, 4'b0010, 2'd0, 2'd0, ARB_OWN,  1'b0},
         '{4'b0110, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0, 4'b0, 4'b0100, 2'd1, 2'd0, ARB_OWN,  1'b0},
         '{4'b0110, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0, 4'b0, 4'b0010, 2'd2, 2'd0, ARB_OWN,  1'b0},
         '{4'b0110, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0, 4'b0, 4'b0100, 2'd1, 2'd0, ARB_OWN,  1'b0},
         '{4'b0110, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0, 4'b0, 4'b0010, 2'd2, 2'd0, ARB_OWN,  1'b0},
         '{4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 1'b0, 4'b0, 4'b0001, 2'd1, 2'd0, ARB_IDLE, 1'b0},
         '{4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 1'b0, 4'b0, 4'b0001, 2'd0, 2'd0, ARB_IDLE, 1'b0}
      };
      do_reset();
      foreach (tbl[i]) begin
         apply(tbl[i]); exp_q.push_back(tbl[i]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         n_tests++; if (bus_if.HGRANT !== e.grant) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b need %b", i, bus_if.HGRANT, e.grant); end
         n_tests++; if (bus_if.HMASTER !== e.master) begin n_fail++; $display("FAIL rr_master[%0d]: got %0d need %0d", i, bus_if.HMASTER, e.master); end
         n_tests++; if (dut.state_q !== e.st) begin n_fail++; $display("FAIL rr_state[%0d]: got %0d need %0d", i, dut.state_q, e.st); end
      end
   endtask

   task automatic test_burst();
      step_t e;
      step_t tbl[6] = '{
         '{4'b0010, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 1'b0, 4'b0, 4'b0010, 2'd0, 2'd0, ARB_OWN,   1'b0},
         '{4'b0110, HTRANS_NONSEQ, HBURST_INCR4,  1'b1, 1'b0, 4'b0, 4'b0010, 2'd1, 2'd1, ARB_BURST, 1'b0},
         '{4'b0100, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 1'b0, 4'b0, 4'b0010, 2'd1, 2'd2, ARB_BURST, 1'b0},
         '{4'b0100, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 1'b0, 4'b0, 4'b0010, 2'd1, 2'd3, ARB_BURST, 1'b0},
         '{4'b0100, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 1'b0, 4'b0, 4'b0100, 2'd1, 2'd0, ARB_OWN,   1'b0},
         '{4'b0100, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 1'b0, 4'b0, 4'b0100, 2'd2, 2'd0, ARB_OWN,   1'b0}
      };
      do_reset();
      foreach (tbl[i]) begin
         apply(tbl[i]); exp_q.push_back(tbl[i]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         n_tests++; if (bus_if.HGRANT !== e.grant) begin n_fail++; $display("FAIL burst_grant[%0d]: got %b need %b", i, bus_if.HGRANT, e.grant); end
         n_tests++; if (bus_if.HMASTER !== e.master) begin n_fail++; $display("FAIL burst_master[%0d]: got %0d need %0d", i, bus_if.HMASTER, e.master); end
         n_tests++; if (dut.beat_cnt_q !== e.cnt) begin n_fail++; $display("FAIL burst_cnt[%0d]: got %0d need %0d", i, dut.beat_cnt_q, e.cnt); end
         n_tests++; if (dut.state_q !== e.st) begin n_fail++; $display("FAIL burst_state[%0d]: got %0d need %0d", i, dut.state_q, e.st); end
      end
   endtask

   task automatic test_burst_wait();
      step_t e;
      step_t tbl[8] = '{
         '{4'b0010, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 1'b0, 4'b0, 4'b0010, 2'd0, 2'd0, ARB_OWN,   1'b0},
         '{4'b0110, HTRANS_NONSEQ, HBURST_INCR4,  1'b1, 1'b0, 4'b0, 4'b0010, 2'd1, 2'd1, ARB_BURST, 1'b0},
         '{4'b0110, HTRANS_SEQ,    HBURST_INCR4,  1'b0, 1'b0, 4'b0, 4'b0010, 2'd1, 2'd1, ARB_BURST, 1'b0},
         '{4'b0110, HTRANS_SEQ,    HBURST_INCR4,  1'b0, 1'b0, 4'b0, 4'b0010, 2'd1, 2'd1, ARB_BURST, 1'b0},
         '{4'b0110, HTRANS_SEQ,    HBURST_INCR4,  1'b0, 1'b0, 4'b0, 4'b0010, 2'd1, 2'd1, ARB_BURST, 1'b0},
         '{4'b0110, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 1'b0, 4'b0, 4'b0010, 2'd1, 2'd2, ARB_BURST, 1'b0},
         '{4'b0110, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 1'b0, 4'b0, 4'b0010, 2'd1, 2'd3, ARB_BURST, 1'b0},
         '{4'b0110, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 1'b0, 4'b0, 4'b0100, 2'd1, 2'd0, ARB_OWN,   1'b0}
      };
      do_reset();
      foreach (tbl[i]) begin
         apply(tbl[i]); exp_q.push_back(tbl[i]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         n_tests++; if (bus_if.HGRANT !== e.grant) begin n_fail++; $display("FAIL wait_grant[%0d]: got %b need %b", i, bus_if.HGRANT, e.grant); end
         n_tests++; if (bus_if.HMASTER !== e.master) begin n_fail++; $display("FAIL wait_master[%0d]: got %0d need %0d", i, bus_if.HMASTER, e.master); end
         n_tests++; if (dut.beat_cnt_q !== e.cnt) begin n_fail++; $display("FAIL wait_cnt[%0d]: got %0d need %0d", i, dut.beat_cnt_q, e.cnt); end
      end
   endtask

   task automatic test_reset_mid_burst();
      step_t e;
      step_t tbl[5] = '{
         '{4'b0010, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 1'b0, 4'b0, 4'b0010, 2'd0, 2'd0, ARB_OWN,   1'b0},
         '{4'b0110, HTRANS_NONSEQ, HBURST_INCR4,  1'b1, 1'b0, 4'b0, 4'b0010, 2'd1, 2'd1, ARB_BURST, 1'b0},
         '{4'b0110, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 1'b0, 4'b0, 4'b0010, 2'd1, 2'd2, ARB_BURST, 1'b0},
         '{4'b0110, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 1'b1, 4'b0, 4'b0001, 2'd0, 2'd0, ARB_IDLE,  1'b0},
         '{4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 1'b0, 4'b0, 4'b0001, 2'd0, 2'd0, ARB_IDLE,  1'b0}
      };
      do_reset();
      foreach (tbl[i]) begin
         apply(tbl[i]); exp_q.push_back(tbl[i]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         n_tests++; if (bus_if.HGRANT !== e.grant) begin n_fail++; $display("FAIL rstb_grant[%0d]: got %b need %b", i, bus_if.HGRANT, e.grant); end
         n_tests++; if (bus_if.HMASTER !== e.master) begin n_fail++; $display("FAIL rstb_master[%0d]: got %0d need %0d", i, bus_if.HMASTER, e.master); end
         n_tests++; if (dut.beat_cnt_q !== e.cnt) begin n_fail++; $display("FAIL rstb_cnt[%0d]: got %0d need %0d", i, dut.beat_cnt_q, e.cnt); end
         n_tests++; if (dut.state_q !== e.st) begin n_fail++; $display("FAIL rstb_state[%0d]: got %0d need %0d", i, dut.state_q, e.st); end
      end
   endtask

`ifdef AHB_ARB_LOCK_EN
   task automatic test_lock();
      step_t e;
      step_t tbl[7] = '{
         '{4'b1000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 1'b0, 4'b0000, 4'b1000, 2'd0, 2'd0, ARB_OWN, 1'b0},
         '{4'b1001, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0, 4'b1000, 4'b1000, 2'd3, 2'd0, ARB_OWN, 1'b1},
         '{4'b1001, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0, 4'b1000, 4'b1000, 2'd3, 2'd0, ARB_OWN, 1'b1},
         '{4'b1001, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0, 4'b1000, 4'b1000, 2'd3, 2'd0, ARB_OWN, 1'b1},
         '{4'b1001, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0, 4'b0000, 4'b1000, 2'd3, 2'd0, ARB_OWN, 1'b0},
         '{4'b1001, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0, 4'b0000, 4'b0001, 2'd3, 2'd0, ARB_OWN, 1'b0},
         '{4'b1001, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0, 4'b0000, 4'b1000, 2'd0, 2'd0, ARB_OWN, 1'b0}
      };
      do_reset();
      foreach (tbl[i]) begin
         apply(tbl[i]); exp_q.push_back(tbl[i]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         n_tests++; if (bus_if.HGRANT !== e.grant) begin n_fail++; $display("FAIL lock_grant[%0d]: got %b need %b", i, bus_if.HGRANT, e.grant); end
         n_tests++; if (bus_if.HMASTER !== e.master) begin n_fail++; $display("FAIL lock_master[%0d]: got %0d need %0d", i, bus_if.HMASTER, e.master); end
         n_tests++; if (bus_if.HMASTLOCK !== e.mlock) begin n_fail++; $display("FAIL lock_mastlock[%0d]: got %b need %b", i, bus_if.HMASTLOCK, e.mlock); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_round_robin();
      test_burst();
      test_burst_wait();
      test_reset_mid_burst();
`ifdef AHB_ARB_LOCK_EN
      test_lock();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
